// File: rtl/dff_bank_arbiter_if.sv
// rtl/dff_bank_arbiter_if.sv - requester/arbiter bundle for the two-client DFF bank arbiter
interface dff_bank_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic             req_a;
  logic             we_a;
  logic [AW-1:0]    addr_a;
  logic [WIDTH-1:0] wdata_a;
  logic             req_b;
  logic             we_b;
  logic [AW-1:0]    addr_b;
  logic [WIDTH-1:0] wdata_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             done_a;
  logic             done_b;
  logic [WIDTH-1:0] rdata;
  logic             busy;

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  gnt_a, gnt_b, done_a, done_b, rdata, busy
  );

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output gnt_a, gnt_b, done_a, done_b, rdata, busy
  );
endinterface

// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin two-requester arbiter over a store-enabled DFF word bank
module dff_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input logic               clk,
  input logic               rst_n,
  dff_bank_arbiter_if.slave bus
);
  localparam int DEPTH = 2 ** AW;

  // GRANT, ACCESS and RESP form the fixed three-cycle busy window of every access
  typedef enum logic [1:0] {IDLE, GRANT, ACCESS, RESP} state_t;

  state_t           state, state_d;
  logic             last_b, last_b_d;
  logic             win_b;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             gnt_a_q, gnt_b_q, done_a_q, done_b_q, busy_q;
  logic             gnt_a_d, gnt_b_d, done_a_d, done_b_d, busy_d;
  logic             latch, pick_b, rd_en;
  logic [DEPTH-1:0] store_en;
  logic [WIDTH-1:0] bank [DEPTH];

  always_comb begin
    state_d  = state;
    last_b_d = last_b;
    latch    = 1'b0;
    pick_b   = 1'b0;
    rd_en    = 1'b0;
    store_en = '0;
    gnt_a_d  = 1'b0;
    gnt_b_d  = 1'b0;
    done_a_d = 1'b0;
    done_b_d = 1'b0;
    case (state)
      IDLE: begin
        // on a tie the requester that was not served last wins
        pick_b = bus.req_b && (!bus.req_a || !last_b);
        if (bus.req_a || bus.req_b) begin
          latch   = 1'b1;
          gnt_a_d = !pick_b;
          gnt_b_d = pick_b;
          state_d = GRANT;
        end
      end
      GRANT: state_d = ACCESS;
      ACCESS: begin
        if (we_q) store_en[addr_q] = 1'b1;
        else      rd_en = 1'b1;
        done_a_d = !win_b;
        done_b_d = win_b;
        state_d  = RESP;
      end
      RESP: begin
        last_b_d = win_b;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_b   <= 1'b1;
      win_b    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      done_a_q <= 1'b0;
      done_b_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_d;
      last_b   <= last_b_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      done_a_q <= done_a_d;
      done_b_q <= done_b_d;
      busy_q   <= busy_d;
      if (latch) begin
        win_b   <= pick_b;
        we_q    <= pick_b ? bus.we_b    : bus.we_a;
        addr_q  <= pick_b ? bus.addr_b  : bus.addr_a;
        wdata_q <= pick_b ? bus.wdata_b : bus.wdata_a;
      end
      if (rd_en) rdata_q <= bank[addr_q];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    always_ff @(posedge clk) begin
      if (!rst_n)           bank[i] <= '0;
      else if (store_en[i]) bank[i] <= wdata_q;
    end
  end

  assign bus.gnt_a  = gnt_a_q;
  assign bus.gnt_b  = gnt_b_q;
  assign bus.done_a = done_a_q;
  assign bus.done_b = done_b_q;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - directed vector bench for dff_bank_arbiter
module tb_dff_bank_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dff_bank_arbiter_if #(.WIDTH(8), .AW(3)) bus ();

  dff_bank_arbiter #(.WIDTH(8), .AW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic       ra, rb;
    logic       wa;
    logic [2:0] aa;
    logic [7:0] da;
    logic       wb;
    logic [2:0] ab;
    logic [7:0] db;
    logic       exp_b;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.req_a = 1'b0; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
  endtask

  function automatic logic [4:0] outs();
    return {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b, bus.busy};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("reset_outs", outs(), 5'b00000);
    check("reset_rdata", bus.rdata, 8'h00);
    rst_n = 1'b1;
  endtask

  // one full access starting at a negedge while the arbiter is idle
  task automatic do_access(input string name, input vec_t v);
    int waited;
    bus.req_a = v.ra; bus.we_a = v.wa; bus.addr_a = v.aa; bus.wdata_a = v.da;
    bus.req_b = v.rb; bus.we_b = v.wb; bus.addr_b = v.ab; bus.wdata_b = v.db;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!(bus.gnt_a || bus.gnt_b) && waited < 8);
    check({name, "/gnt_latency"}, waited, 1);
    check({name, "/grant"}, outs(), {!v.exp_b, v.exp_b, 3'b001});
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    @(negedge clk);
    check({name, "/access"}, outs(), 5'b00001);
    @(negedge clk);
    check({name, "/done"}, outs(), {2'b00, !v.exp_b, v.exp_b, 1'b1});
    check({name, "/rdata"}, bus.rdata, v.exp_rd);
    @(negedge clk);
    check({name, "/idle"}, outs(), 5'b00000);
  endtask

  function automatic vec_t mk(input logic ra, rb, wa, input logic [2:0] aa, input logic [7:0] da,
                              input logic wb, input logic [2:0] ab, input logic [7:0] db,
                              input logic exp_b, input logic [7:0] exp_rd);
    vec_t v;
    v.ra = ra; v.rb = rb; v.wa = wa; v.aa = aa; v.da = da;
    v.wb = wb; v.ab = ab; v.db = db; v.exp_b = exp_b; v.exp_rd = exp_rd;
    return v;
  endfunction

  initial begin
    logic gq[$];
    logic dq[$];
    logic exp_order[4];
    exp_order[0] = 1'b0; exp_order[1] = 1'b1; exp_order[2] = 1'b0; exp_order[3] = 1'b1;

    for (int i = 0; i < 8; i++)
      vecs[i] = mk(0, 1, 0, 0, 8'h00, 0, 3'(i), 8'h00, 1, 8'h00);
    vecs[8]  = mk(1, 0, 1, 3, 8'hA5, 0, 0, 8'h00, 0, 8'h00);
    vecs[9]  = mk(1, 0, 0, 3, 8'h00, 0, 0, 8'h00, 0, 8'hA5);
    vecs[10] = mk(0, 1, 0, 0, 8'h00, 1, 7, 8'hFF, 1, 8'hA5);
    vecs[11] = mk(1, 0, 0, 7, 8'h00, 0, 0, 8'h00, 0, 8'hFF);
    vecs[12] = mk(1, 0, 0, 6, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    vecs[13] = mk(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00);
    vecs[14] = mk(1, 1, 0, 3, 8'h00, 0, 7, 8'h00, 1, 8'hFF);
    vecs[15] = mk(1, 1, 0, 3, 8'h00, 0, 7, 8'h00, 0, 8'hA5);

    idle_inputs();
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 16; i++)
      do_access($sformatf("vec%0d", i), vecs[i]);

    // both requesters held: grants must alternate and done order must follow
    do_reset();
    bus.req_a = 1; bus.we_a = 1; bus.addr_a = 1; bus.wdata_a = 8'h11;
    bus.req_b = 1; bus.we_b = 1; bus.addr_b = 2; bus.wdata_b = 8'h22;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      check("alt/gnt_excl", bus.gnt_a & bus.gnt_b, 0);
      check("alt/done_excl", bus.done_a & bus.done_b, 0);
      if (bus.gnt_a || bus.gnt_b) gq.push_back(bus.gnt_b);
      if (bus.done_a || bus.done_b) dq.push_back(bus.done_b);
    end
    idle_inputs();
    check("alt/n_gnt", gq.size(), 4);
    check("alt/n_done", dq.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < gq.size()) check($sformatf("alt/gnt%0d", k), gq[k], exp_order[k]);
      if (k < dq.size()) check($sformatf("alt/done%0d", k), dq[k], exp_order[k]);
    end
    @(negedge clk);
    do_access("alt/rd1", mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 8'h11));
    do_access("alt/rd2", mk(0, 1, 0, 0, 0, 0, 2, 0, 1, 8'h22));

    // reset landing on the edge that would commit an A write
    do_access("rst/pre_wr", mk(1, 0, 1, 2, 8'h5A, 0, 0, 0, 0, 8'h22));
    do_access("rst/pre_rd", mk(1, 0, 0, 2, 8'h00, 0, 0, 0, 0, 8'h5A));
    bus.req_a = 1; bus.we_a = 1; bus.addr_a = 5; bus.wdata_a = 8'h3C;
    @(negedge clk);
    check("rst/gnt_a", outs(), 5'b10001);
    bus.req_a = 0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst/outs", outs(), 5'b00000);
    check("rst/rdata", bus.rdata, 8'h00);
    rst_n = 1'b1;
    do_access("rst/tie_rd5", mk(1, 1, 0, 5, 0, 0, 2, 0, 0, 8'h00));

    // fields change right after grant; the latched request must be used
    bus.req_a = 1; bus.we_a = 1; bus.addr_a = 4; bus.wdata_a = 8'h77;
    @(negedge clk);
    check("chg/gnt_a", outs(), 5'b10001);
    bus.req_a = 0; bus.addr_a = 6; bus.wdata_a = 8'h99;
    repeat (3) @(negedge clk);
    check("chg/idle", outs(), 5'b00000);
    do_access("chg/rd4", mk(1, 0, 0, 4, 0, 0, 0, 0, 0, 8'h77));
    do_access("chg/rd6", mk(1, 0, 0, 6, 0, 0, 0, 0, 0, 8'h00));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
